// File: rtl/keccak_perm_requester.sv
// Initiator for the Keccak-p[1600] round controller: accepts one job at a time, pulses load/start,
// and returns a tagged result with the measured latency. Optional watchdog: KECCAK_PERM_REQ_WATCHDOG_EN.
module keccak_perm_requester #(
  parameter int TAG_W          = 4,
  parameter int MAX_ROUNDS     = 24,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [4:0]       i_job_rounds,
  input  logic [TAG_W-1:0] i_job_tag,
  output logic             o_perm_load,
  output logic             o_perm_start,
  output logic [4:0]       o_perm_num_rounds,
  input  logic             i_perm_done,
  output logic             o_perm_rst,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [TAG_W-1:0] o_res_tag,
  output logic [5:0]       o_res_cycles,
  output logic             o_res_timeout,
  output logic             o_busy,
  output logic             o_err_spurious,
  output logic [31:0]      o_jobs_done
);

`ifdef KECCAK_PERM_REQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);
  localparam logic [5:0] TO_C  = 6'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [4:0]       rounds_q, rounds_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [5:0]       cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic             perm_rst_q, perm_rst_d;
  logic             err_q, err_d;
  logic [31:0]      jobs_q, jobs_d;

  logic [4:0] rounds_clamped;
  logic [5:0] cnt_inc;
  logic       wd_hit;

  assign rounds_clamped = (i_job_rounds > MAX_R) ? MAX_R : i_job_rounds;
  assign cnt_inc        = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
  // Fires on the WAIT cycle that would report TIMEOUT_CYCLES; a done in that cycle still wins.
  assign wd_hit         = WD_EN && (cnt_q == TO_C - 6'd1);

  always_comb begin
    state_d    = state_q;
    rounds_d   = rounds_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    perm_rst_d = 1'b0;
    jobs_d     = jobs_q;
    err_d      = err_q | (i_perm_done && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (i_job_valid) begin
          tag_d    = i_job_tag;
          rounds_d = rounds_clamped;
          if (rounds_clamped == 5'd0) begin
            cycles_d = 6'd0;
            state_d  = S_HOLD;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        cnt_d   = 6'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (i_perm_done) begin
          cycles_d = cnt_inc;
          state_d  = S_HOLD;
        end else if (wd_hit) begin
          perm_rst_d = 1'b1;
          timeout_d  = 1'b1;
          cycles_d   = TO_C;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_res_ready) begin
          jobs_d    = jobs_q + 32'd1;
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rounds_q   <= MAX_R;
      tag_q      <= '0;
      cnt_q      <= 6'd0;
      cycles_q   <= 6'd0;
      timeout_q  <= 1'b0;
      perm_rst_q <= 1'b0;
      err_q      <= 1'b0;
      jobs_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      rounds_q   <= rounds_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      perm_rst_q <= perm_rst_d;
      err_q      <= err_d;
      jobs_q     <= jobs_d;
    end
  end

  assign o_job_ready       = (state_q == S_IDLE);
  assign o_busy            = (state_q != S_IDLE);
  assign o_perm_load       = (state_q == S_LOAD);
  assign o_perm_start      = (state_q == S_START);
  assign o_res_valid       = (state_q == S_HOLD);
  assign o_perm_num_rounds = rounds_q;
  assign o_res_tag         = tag_q;
  assign o_res_cycles      = cycles_q;
  assign o_err_spurious    = err_q;
  assign o_jobs_done       = jobs_q;

`ifdef KECCAK_PERM_REQ_WATCHDOG_EN
  assign o_perm_rst    = perm_rst_q;
  assign o_res_timeout = timeout_q;
`else
  assign o_perm_rst    = 1'b0;
  assign o_res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_perm_requester.sv
// Self-checking bench for keccak_perm_requester: vector table, hand-written corner sequences,
// and randomized jobs checked against a latency/clamp model.
module tb_keccak_perm_requester;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_job_valid;
  logic        o_job_ready;
  logic [4:0]  i_job_rounds;
  logic [3:0]  i_job_tag;
  logic        o_perm_load;
  logic        o_perm_start;
  logic [4:0]  o_perm_num_rounds;
  logic        i_perm_done;
  logic        o_perm_rst;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [3:0]  o_res_tag;
  logic [5:0]  o_res_cycles;
  logic        o_res_timeout;
  logic        o_busy;
  logic        o_err_spurious;
  logic [31:0] o_jobs_done;

`ifdef KECCAK_PERM_REQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  keccak_perm_requester #(.TAG_W(4), .MAX_ROUNDS(24), .TIMEOUT_CYCLES(63)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_rounds(i_job_rounds), .i_job_tag(i_job_tag),
    .o_perm_load(o_perm_load), .o_perm_start(o_perm_start),
    .o_perm_num_rounds(o_perm_num_rounds), .i_perm_done(i_perm_done),
    .o_perm_rst(o_perm_rst), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_tag(o_res_tag), .o_res_cycles(o_res_cycles), .o_res_timeout(o_res_timeout),
    .o_busy(o_busy), .o_err_spurious(o_err_spurious), .o_jobs_done(o_jobs_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int jobs_model = 0;

  typedef struct {
    int rounds;
    int tag;
    int delay;
    int hold_wait;
    int exp_rounds;
    int exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_job_ready", 32'(o_job_ready), 1);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_load", 32'(o_perm_load), 0);
    check("rst_start", 32'(o_perm_start), 0);
    check("rst_perm_rst", 32'(o_perm_rst), 0);
    check("rst_res_valid", 32'(o_res_valid), 0);
    check("rst_timeout", 32'(o_res_timeout), 0);
    check("rst_err", 32'(o_err_spurious), 0);
    check("rst_tag", 32'(o_res_tag), 0);
    check("rst_cycles", 32'(o_res_cycles), 0);
    check("rst_jobs", o_jobs_done, 0);
    check("rst_num_rounds", 32'(o_perm_num_rounds), 24);
  endtask

  // One job end to end; the core model raises done 'delay' cycles after the start pulse.
  task automatic run_job(input int rounds, input int tag, input int delay, input int hold_wait,
                         input int exp_rounds, input int exp_cycles);
    int c, start_c, loads, starts, rsts, hold_c, w, exp_hold;
    bit got, exp_to;
    exp_to = WD && (exp_rounds != 0) && (delay > 63);
    w = 0;
    while (!o_job_ready && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    check("job_ready_idle", 32'(o_job_ready), 1);
    i_job_valid  = 1'b1;
    i_job_rounds = 5'(rounds);
    i_job_tag    = 4'(tag);
    c = 0; start_c = -1; loads = 0; starts = 0; rsts = 0; got = 1'b0; hold_c = 0;
    while (!got && c < 300) begin
      @(negedge i_clk);
      c++;
      i_job_valid = 1'b0;
      i_perm_done = 1'b0;
      if (o_perm_load) loads++;
      if (o_perm_start) begin
        starts++;
        start_c = c;
      end
      if (o_perm_rst) rsts++;
      if (o_res_valid) begin
        got = 1'b1;
        hold_c = c;
      end else if (start_c > 0 && c == start_c + delay && !exp_to) begin
        i_perm_done = 1'b1;
      end
    end
    exp_hold = (exp_rounds == 0) ? 1 : (exp_to ? 3 + 63 : 3 + delay);
    check("res_valid_seen", 32'(got), 1);
    check("hold_latency", 32'(hold_c), 32'(exp_hold));
    check("load_pulses", 32'(loads), (exp_rounds != 0) ? 1 : 0);
    check("start_pulses", 32'(starts), (exp_rounds != 0) ? 1 : 0);
    check("perm_rst_pulses", 32'(rsts), exp_to ? 1 : 0);
    if (exp_rounds != 0) check("start_cycle", 32'(start_c), 2);
    check("num_rounds", 32'(o_perm_num_rounds), 32'(exp_rounds));
    check("res_tag", 32'(o_res_tag), 32'(tag & 15));
    check("res_cycles", 32'(o_res_cycles), 32'(exp_cycles));
    check("res_timeout", 32'(o_res_timeout), exp_to ? 1 : 0);
    check("busy_hold", 32'(o_busy), 1);
    for (int i = 0; i < hold_wait; i++) begin
      @(negedge i_clk);
      check("hold_valid", 32'(o_res_valid), 1);
      check("hold_tag", 32'(o_res_tag), 32'(tag & 15));
      check("hold_cycles", 32'(o_res_cycles), 32'(exp_cycles));
      check("hold_not_ready", 32'(o_job_ready), 0);
    end
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    jobs_model++;
    check("post_valid", 32'(o_res_valid), 0);
    check("post_job_ready", 32'(o_job_ready), 1);
    check("post_timeout", 32'(o_res_timeout), 0);
    check("jobs_done", o_jobs_done, 32'(jobs_model));
    $display("job rounds=%0d tag=%0h delay=%0d -> cycles=%0d timeout=%0b jobs=%0d",
             rounds, tag, delay, o_res_cycles, exp_to, o_jobs_done);
  endtask

  initial begin
    int r, d, er, ec;
    i_rst = 1'b1; i_job_valid = 1'b0; i_job_rounds = '0; i_job_tag = '0;
    i_perm_done = 1'b0; i_res_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_values();
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_values();

    vecs[0] = '{24, 'h5, 25, 0, 24, 25};
    vecs[1] = '{31, 'h3, 10, 0, 24, 10};
    vecs[2] = '{0,  'hA, 5,  0, 0,  0};
    vecs[3] = '{7,  'h9, 12, 10, 7, 12};
    vecs[4] = '{1,  'h1, 1,  0, 1,  1};
    vecs[5] = '{20, 'hF, 70, 0, 20, 63};
    vecs[6] = '{24, 'h6, 63, 2, 24, 63};
    foreach (vecs[k])
      run_job(vecs[k].rounds, vecs[k].tag, vecs[k].delay, vecs[k].hold_wait,
              vecs[k].exp_rounds, vecs[k].exp_cycles);

    // result-ready with no result pending must not count
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    @(negedge i_clk);
    check("idle_ready_no_effect", o_jobs_done, 32'(jobs_model));
    check("idle_still_ready", 32'(o_job_ready), 1);

    // spurious done in IDLE sets the sticky flag; a normal job still completes
    i_perm_done = 1'b1;
    @(negedge i_clk);
    i_perm_done = 1'b0;
    check("spurious_set", 32'(o_err_spurious), 1);
    run_job(12, 'h4, 13, 0, 12, 13);
    check("spurious_sticky", 32'(o_err_spurious), 1);

    // reset in WAIT, with done in the reset cycle: reset wins, job dropped
    i_job_valid = 1'b1; i_job_rounds = 5'd10; i_job_tag = 4'h7;
    @(negedge i_clk);
    i_job_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    check("busy_in_wait", 32'(o_busy), 1);
    i_rst = 1'b1;
    i_perm_done = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_perm_done = 1'b0;
    jobs_model = 0;
    check_reset_values();
    run_job(10, 'h7, 20, 1, 10, 20);

    for (int n = 0; n < 25; n++) begin
      r  = int'($urandom_range(0, 31));
      d  = int'($urandom_range(1, 70));
      er = (r > 24) ? 24 : r;
      ec = (er == 0) ? 0 : ((d > 63) ? 63 : d);
      run_job(r, int'($urandom_range(0, 15)), d, int'($urandom_range(0, 3)), er, ec);
    end
    check("no_spurious_after_reset", 32'(o_err_spurious), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
